// File: rtl/fifo_burst_drain_pkg.sv
// Shared types for the rclk-domain burst drain: FSM state encoding and output buffer sizing.
package fifo_burst_drain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo_burst_drain_if.sv
// Command, FWFT FIFO read port and output stream of the burst drain.
// master = the drain itself; slave = the FIFO/sequencer side.
interface fifo_burst_drain_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
);
   logic                  start;
   logic [LEN_WIDTH-1:0]  len;
   logic                  busy;
   logic                  done;
   logic                  fifo_nempty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_re;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      input  start, len, fifo_nempty, fifo_data, out_ready,
      output busy, done, fifo_re, out_valid, out_data, out_last
   );

   modport slave (
      output start, len, fifo_nempty, fifo_data, out_ready,
      input  busy, done, fifo_re, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fifo_burst_skid2.sv
// Purpose: 2-entry in-order register buffer; head is always entry 0.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: a push into a full buffer is dropped unless a pop frees a slot that cycle.
module fifo_burst_skid2
   import fifo_burst_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] head,
   output cnt_t                  cnt
);
   logic [DATA_WIDTH-1:0] mem0;
   logic [DATA_WIDTH-1:0] mem1;
   cnt_t                  cnt_q;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop  = pop && (cnt_q != '0);
   assign do_push = push && ((cnt_q != cnt_t'(SKID_DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0  <= '0;
         mem1  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt_q == '0) mem0 <= push_data;
               else             mem1 <= push_data;
               cnt_q <= cnt_q + 1'b1;
            end
            2'b01: begin
               mem0  <= mem1;
               cnt_q <= cnt_q - 1'b1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind whatever remains.
               if (cnt_q == cnt_t'(1)) begin
                  mem0 <= push_data;
               end else begin
                  mem0 <= mem1;
                  mem1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = mem0;
   assign cnt  = cnt_q;
endmodule

// File: rtl/fifo_burst_drain.sv
// Purpose: drain exactly len+1 words from an FWFT FIFO into a valid/ready stream, flag the last word (abort input with FIFO_BURST_DRAIN_ABORT_EN).
// Latency: start -> busy 1 cycle; FIFO pop -> out_valid 1 cycle; last accept -> done 1 cycle.
// Backpressure: out_ready low fills the 2-entry buffer, then fifo_re stays low; no out_ready -> fifo_re path.
module fifo_burst_drain
   import fifo_burst_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
) (
   input  logic clk,
   input  logic rst_n,
`ifdef FIFO_BURST_DRAIN_ABORT_EN
   input  logic abort,
`endif
   fifo_burst_drain_if.master bus
);
   typedef logic [LEN_WIDTH:0] rem_t;

   state_t                state;
   state_t                state_nxt;
   rem_t                  fetch_rem;
   rem_t                  deliv_rem;
   cnt_t                  cnt;
   logic [DATA_WIDTH-1:0] head;
   logic                  pop;
   logic                  kill;
   logic                  accept_last;
   logic                  launch;

`ifdef FIFO_BURST_DRAIN_ABORT_EN
   assign kill = abort && (state == RUN);
`else
   assign kill = 1'b0;
`endif

   assign launch      = (state == IDLE) && bus.start;
   assign bus.out_valid = (cnt != '0);
   assign bus.out_data  = head;
   assign bus.out_last  = bus.out_valid && (deliv_rem == rem_t'(1));
   assign pop         = bus.out_valid && bus.out_ready;
   assign accept_last = pop && bus.out_last;
   assign bus.busy    = (state == RUN);
   assign bus.done    = (state == DONE);

   // Fetch gating looks only at local occupancy, never at out_ready.
   assign bus.fifo_re = (state == RUN) && bus.fifo_nempty && (fetch_rem != '0) &&
                        (cnt < cnt_t'(SKID_DEPTH)) && !kill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN: begin
            if (kill)             state_nxt = IDLE;
            else if (accept_last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_rem <= '0;
         deliv_rem <= '0;
      end else if (launch) begin
         fetch_rem <= rem_t'(bus.len) + rem_t'(1);
         deliv_rem <= rem_t'(bus.len) + rem_t'(1);
      end else if (kill) begin
         fetch_rem <= '0;
         deliv_rem <= '0;
      end else begin
         if (bus.fifo_re)                fetch_rem <= fetch_rem - rem_t'(1);
         if (pop && (deliv_rem != '0))   deliv_rem <= deliv_rem - rem_t'(1);
      end
   end

   fifo_burst_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bus.fifo_re),
      .push_data (bus.fifo_data),
      .pop       (pop),
      .flush     (kill),
      .head      (head),
      .cnt       (cnt)
   );
endmodule

// File: tb/tb_fifo_burst_drain.sv
// Purpose: directed bench for fifo_burst_drain with an FWFT FIFO model and output scoreboard.
// Latency: expected words are queued at stimulus time and popped by an independent monitor.
// Backpressure: out_ready and fifo_nempty are driven by the directed tests below.
module tb_fifo_burst_drain;
   localparam int DW = 16;
   localparam int LW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic ne_en;
   int   vecs = 0;
   int   errs = 0;
   logic [DW-1:0] fq[$];
   logic [DW:0]   exp_q[$];
`ifdef FIFO_BURST_DRAIN_ABORT_EN
   logic abort;
`endif

   always #5 clk = ~clk;

   fifo_burst_drain_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   fifo_burst_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef FIFO_BURST_DRAIN_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fifo_refresh();
      bus.fifo_nempty = ne_en && (fq.size() != 0);
      bus.fifo_data   = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [DW-1:0] base, input int n);
      fq.delete();
      for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
      fifo_refresh();
   endtask

   task automatic sb_push(input logic [DW-1:0] base, input int cnt, input int n);
      for (int i = 0; i < cnt; i++) exp_q.push_back({(i == n - 1), base + DW'(i)});
   endtask

   task automatic run_start(input logic [LW-1:0] l);
      bus.start = 1'b1;
      bus.len   = l;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (bus.done) break;
         n++;
         @(posedge clk);
         #1;
      end
      chk({name, "_done"}, bus.done, 1);
      chk({name, "_busy_at_done"}, bus.busy, 0);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_busy"},      bus.busy,      0);
      chk({name, "_done"},      bus.done,      0);
      chk({name, "_fifo_re"},   bus.fifo_re,   0);
      chk({name, "_out_valid"}, bus.out_valid, 0);
      chk({name, "_out_last"},  bus.out_last,  0);
      chk({name, "_out_data"},  bus.out_data,  0);
   endtask

   // FIFO model: a pop seen before the edge takes effect just after it.
   initial begin : fifo_model
      logic pop_f;
      forever begin
         @(negedge clk);
         pop_f = bus.fifo_re;
         chk("fifo_re_while_empty", pop_f && !bus.fifo_nempty, 0);
         @(posedge clk);
         #1;
         if (pop_f && fq.size() != 0) fq.delete(0);
         fifo_refresh();
      end
   end

   initial begin : monitor
      logic        exp_done;
      logic [DW:0] e;
      exp_done = 1'b0;
      forever begin
         @(negedge clk);
         chk("done_pulse", bus.done, exp_done);
         exp_done = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_data", bus.out_data, e[DW-1:0]);
               chk("out_last", bus.out_last, e[DW]);
               exp_done = e[DW];
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      logic seen;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.out_ready = 1'b1;
      ne_en         = 1'b1;
`ifdef FIFO_BURST_DRAIN_ABORT_EN
      abort         = 1'b0;
`endif
      load(16'h9999, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      step();
      rst_n = 1'b1;
      step();

      // Burst of 4 from 8 preloaded words at full rate
      load(16'hA000, 8);
      sb_push(16'hA000, 4, 4);
      run_start(8'd3);
      wait_done("t1", 40, n);
      chk("t1_latency", n, 5);
      chk("t1_fifo_left", fq.size(), 4);
      chk("t1_fifo_head", fq[0], 16'hA004);
      chk("t1_sb_empty", exp_q.size(), 0);
      step();

      // Single-word burst
      load(16'hB000, 1);
      sb_push(16'hB000, 1, 1);
      run_start(8'd0);
      wait_done("t2", 40, n);
      chk("t2_latency", n, 2);
      step();

      // fifo_nempty toggling 1-0-0
      load(16'hC000, 8);
      sb_push(16'hC000, 8, 8);
      run_start(8'd7);
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         ne_en = (k % 3 == 0);
         fifo_refresh();
         @(negedge clk);
         if (bus.done) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("t3_done", seen, 1);
      chk("t3_sb_empty", exp_q.size(), 0);
      ne_en = 1'b1;
      step();
      fifo_refresh();

      // Downstream stall of 5 cycles mid-burst
      load(16'hD000, 16);
      sb_push(16'hD000, 16, 16);
      run_start(8'd15);
      repeat (5) step();
      bus.out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("t4_stall_valid", bus.out_valid, 1);
         if (s >= 1) chk("t4_stall_fifo_re", bus.fifo_re, 0);
         step();
      end
      bus.out_ready = 1'b1;
      wait_done("t4", 80, n);
      chk("t4_fifo_left", fq.size(), 0);
      chk("t4_sb_empty", exp_q.size(), 0);
      step();

      // Second start while busy is ignored
      load(16'hE000, 10);
      sb_push(16'hE000, 6, 6);
      run_start(8'd5);
      repeat (2) step();
      run_start(8'd2);
      wait_done("t5", 40, n);
      chk("t5_fifo_left", fq.size(), 4);
      chk("t5_fifo_head", fq[0], 16'hE006);
      repeat (4) step();
      @(negedge clk);
      chk("t5_no_restart_busy", bus.busy, 0);
      chk("t5_no_restart_re", bus.fifo_re, 0);
      step();

      // Reset mid-burst, then a normal burst
      load(16'hF000, 8);
      sb_push(16'hF000, 8, 8);
      run_start(8'd7);
      repeat (3) step();
      rst_n = 1'b0;
      @(negedge clk);
      exp_q.delete();
      fq.delete();
      fifo_refresh();
      chk_quiet("midreset");
      step();
      rst_n = 1'b1;
      step();
      load(16'h1000, 2);
      sb_push(16'h1000, 2, 2);
      run_start(8'd1);
      wait_done("t6", 40, n);
      chk("t6_latency", n, 3);
      step();

`ifdef FIFO_BURST_DRAIN_ABORT_EN
      // Abort after 4 delivered words of a 10-word burst
      load(16'h3000, 12);
      sb_push(16'h3000, 4, 10);
      run_start(8'd9);
      repeat (5) step();
      bus.out_ready = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_fifo_left", fq.size(), 7);
      chk("abort_fifo_head", fq[0], 16'h3005);
      repeat (3) step();
      @(negedge clk);
      chk("abort_idle_re", bus.fifo_re, 0);
      bus.out_ready = 1'b1;
      step();
`endif

      repeat (3) step();
      chk("final_sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
